register_file: RTL and testbench

Integer register file with a pending-write scoreboard, the operand-fetch stage that feeds `src_a`/`src_b` into the execute-stage ALU.
- Provides two combinational read ports and one synchronous writeback port.
- Tracks which destination registers have an in-flight producer and raises a stall to hold the issuing instruction until its operands are valid.
- Register 0 is hardwired to zero.

---
 rtl/register_file.sv | 132 +++++++++++++
 tb/tb_register_file.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file
// ---------------------------------------------------------------------------
// Operand-fetch register file with a pending-write scoreboard.  Supplies the
// two ALU source operands combinationally, accepts one writeback per cycle,
// and tracks which destination registers still have an in-flight producer.
// It stalls an issuing instruction while any of its operands, or its
// destination (WAW), is still pending.  Register 0 reads as zero, ignores
// writes and is never marked busy.
//
// Optional feature, selected at compile time:
//   REGFILE_BYPASS_EN  - write-first forwarding.  A writeback is visible on
//                        the read ports, and clears the matching busy
//                        indication, in the same cycle it is presented.
//                        When undefined, reads and busy come from registered
//                        state only.
//
// Ports:
//   clk_i          clock, all state updates on the rising edge
//   rst_i          synchronous active-high reset (clears regs and busy)
//   rs1_addr_i     read port 1 index
//   rs2_addr_i     read port 2 index
//   rs1_data_o     read port 1 data (ALU operand A)
//   rs2_data_o     read port 2 data (ALU operand B)
//   rs1_busy_o     read port 1 register has a pending write
//   rs2_busy_o     read port 2 register has a pending write
//   issue_valid_i  an instruction requests issue this cycle
//   issue_rd_i     destination index of the issuing instruction
//   stall_o        issue refused this cycle
//   wb_en_i        writeback strobe
//   wb_addr_i      writeback index
//   wb_data_i      writeback data
// ---------------------------------------------------------------------------
module register_file #(
   parameter int  NUM_REGS   = 32,
   parameter int  DATA_WIDTH = 32,
   localparam int ADDR_WIDTH = $clog2(NUM_REGS)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [ADDR_WIDTH-1:0] rs1_addr_i,
   input  logic [ADDR_WIDTH-1:0] rs2_addr_i,
   output logic [DATA_WIDTH-1:0] rs1_data_o,
   output logic [DATA_WIDTH-1:0] rs2_data_o,
   output logic                  rs1_busy_o,
   output logic                  rs2_busy_o,
   input  logic                  issue_valid_i,
   input  logic [ADDR_WIDTH-1:0] issue_rd_i,
   output logic                  stall_o,
   input  logic                  wb_en_i,
   input  logic [ADDR_WIDTH-1:0] wb_addr_i,
   input  logic [DATA_WIDTH-1:0] wb_data_i
);

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   busy;
   logic [NUM_REGS-1:0]   busy_next;
   logic                  wb_valid;
   logic                  rd_busy;
   logic                  issue_accept;

   // A writeback to register 0 is a no-op everywhere, so qualify it once.
   assign wb_valid = wb_en_i && (wb_addr_i != '0);

   // Read ports and hazard lookups.  Index 0 is forced to zero data and
   // not-busy rather than relying on the array contents.  With forwarding
   // enabled, a matching writeback overrides both the data and the busy
   // view, so a waiting consumer can issue in the writeback cycle.
   always_comb begin
      rs1_data_o = '0;
      rs2_data_o = '0;
      rs1_busy_o = 1'b0;
      rs2_busy_o = 1'b0;
      rd_busy    = busy[issue_rd_i];
      if (rs1_addr_i != '0) begin
         rs1_data_o = regs[rs1_addr_i];
         rs1_busy_o = busy[rs1_addr_i];
      end
      if (rs2_addr_i != '0) begin
         rs2_data_o = regs[rs2_addr_i];
         rs2_busy_o = busy[rs2_addr_i];
      end
`ifdef REGFILE_BYPASS_EN
      if (wb_valid && (wb_addr_i == rs1_addr_i)) begin
         rs1_data_o = wb_data_i;
         rs1_busy_o = 1'b0;
      end
      if (wb_valid && (wb_addr_i == rs2_addr_i)) begin
         rs2_data_o = wb_data_i;
         rs2_busy_o = 1'b0;
      end
      if (wb_valid && (wb_addr_i == issue_rd_i)) begin
         rd_busy = 1'b0;
      end
`endif
   end

   // Stall is purely combinational: any pending source operand, or a
   // pending write to the destination, holds the issuing instruction.
   assign stall_o      = issue_valid_i && (rs1_busy_o || rs2_busy_o || rd_busy);
   assign issue_accept = issue_valid_i && !stall_o;

   // Scoreboard update.  The clear is applied before the set so that when a
   // register is both written back and claimed by a newly accepted producer
   // in the same cycle, the younger producer keeps it busy.
   always_comb begin
      busy_next = busy;
      if (wb_valid) begin
         busy_next[wb_addr_i] = 1'b0;
      end
      if (issue_accept && (issue_rd_i != '0)) begin
         busy_next[issue_rd_i] = 1'b1;
      end
      busy_next[0] = 1'b0;
   end

   // State registers.  Reset wipes all data and all pending writes, and any
   // writeback or issue presented in the reset cycle is discarded.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs[i] <= '0;
         end
         busy <= '0;
      end else begin
         if (wb_valid) begin
            regs[wb_addr_i] <= wb_data_i;
         end
         busy <= busy_next;
      end
   end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file
// ---------------------------------------------------------------------------
// Self-checking bench for register_file.  A behavioural model (plain arrays
// of register values and pending flags) predicts every output; directed
// scenarios cover reset, x0 handling, RAW/WAW hazards, reset mid-flight and
// dual-port conflicts, followed by a randomized run.
// ---------------------------------------------------------------------------
module tb_register_file;

   localparam int NUM_REGS   = 32;
   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 5;
`ifdef REGFILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   logic                  clk;
   logic                  rst;
   logic [ADDR_WIDTH-1:0] rs1_addr;
   logic [ADDR_WIDTH-1:0] rs2_addr;
   logic [DATA_WIDTH-1:0] rs1_data;
   logic [DATA_WIDTH-1:0] rs2_data;
   logic                  rs1_busy;
   logic                  rs2_busy;
   logic                  issue_valid;
   logic [ADDR_WIDTH-1:0] issue_rd;
   logic                  stall;
   logic                  wb_en;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [DATA_WIDTH-1:0] wb_data;

   int checks = 0;
   int errors = 0;

   logic [DATA_WIDTH-1:0] model_regs [NUM_REGS];
   bit                    model_busy [NUM_REGS];

   register_file #(
      .NUM_REGS   (NUM_REGS),
      .DATA_WIDTH (DATA_WIDTH)
   ) dut (
      .clk_i         (clk),
      .rst_i         (rst),
      .rs1_addr_i    (rs1_addr),
      .rs2_addr_i    (rs2_addr),
      .rs1_data_o    (rs1_data),
      .rs2_data_o    (rs2_data),
      .rs1_busy_o    (rs1_busy),
      .rs2_busy_o    (rs2_busy),
      .issue_valid_i (issue_valid),
      .issue_rd_i    (issue_rd),
      .stall_o       (stall),
      .wb_en_i       (wb_en),
      .wb_addr_i     (wb_addr),
      .wb_data_i     (wb_data)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Expected read data: x0 is zero; a same-cycle writeback forwards only
   // when bypass is built in; otherwise the last committed value.
   function automatic logic [DATA_WIDTH-1:0] expData(input logic [ADDR_WIDTH-1:0] a);
      if (a == 0) return '0;
      if (BYPASS && wb_en && wb_addr == a) return wb_data;
      return model_regs[a];
   endfunction

   // Expected pending flag for a register as seen this cycle.
   function automatic bit expBusy(input logic [ADDR_WIDTH-1:0] a);
      if (a == 0) return 1'b0;
      if (BYPASS && wb_en && wb_addr == a) return 1'b0;
      return model_busy[a];
   endfunction

   function automatic bit expStall();
      return issue_valid && (expBusy(rs1_addr) || expBusy(rs2_addr) || expBusy(issue_rd));
   endfunction

   // One comparison: counted, and reported on mismatch.
   task automatic checkValue(input string tag, input logic [DATA_WIDTH-1:0] observed,
                             input logic [DATA_WIDTH-1:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one cycle's inputs just after the falling edge and let the
   // combinational outputs settle.
   task automatic applyStimulus(input logic r, input logic [ADDR_WIDTH-1:0] a1,
                                input logic [ADDR_WIDTH-1:0] a2, input logic iv,
                                input logic [ADDR_WIDTH-1:0] rd, input logic we,
                                input logic [ADDR_WIDTH-1:0] wa,
                                input logic [DATA_WIDTH-1:0] wd);
      rst         = r;
      rs1_addr    = a1;
      rs2_addr    = a2;
      issue_valid = iv;
      issue_rd    = rd;
      wb_en       = we;
      wb_addr     = wa;
      wb_data     = wd;
      #1;
   endtask

   // Compare every output against the model for the current inputs.
   task automatic checkOutput();
      checkValue("rs1_data", rs1_data, expData(rs1_addr));
      checkValue("rs2_data", rs2_data, expData(rs2_addr));
      checkValue("rs1_busy", 32'(rs1_busy), 32'(expBusy(rs1_addr)));
      checkValue("rs2_busy", 32'(rs2_busy), 32'(expBusy(rs2_addr)));
      checkValue("stall", 32'(stall), 32'(expStall()));
   endtask

   // Take the rising edge and commit the same effects to the model:
   // reset wipes everything, otherwise writeback clears then accepted issue
   // sets (youngest producer wins).
   task automatic advance();
      bit accept;
      accept = issue_valid && !expStall();
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            model_regs[i] = '0;
            model_busy[i] = 1'b0;
         end
      end else begin
         if (wb_en && wb_addr != 0) begin
            model_regs[wb_addr] = wb_data;
            model_busy[wb_addr] = 1'b0;
         end
         if (accept && issue_rd != 0) begin
            model_busy[issue_rd] = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic step(input logic r, input logic [ADDR_WIDTH-1:0] a1,
                       input logic [ADDR_WIDTH-1:0] a2, input logic iv,
                       input logic [ADDR_WIDTH-1:0] rd, input logic we,
                       input logic [ADDR_WIDTH-1:0] wa, input logic [DATA_WIDTH-1:0] wd);
      applyStimulus(r, a1, a2, iv, rd, we, wa, wd);
      checkOutput();
      advance();
   endtask

   function automatic logic [ADDR_WIDTH-1:0] randAddr();
      if ($urandom_range(0, 3) == 0) return ADDR_WIDTH'($urandom_range(0, NUM_REGS - 1));
      return ADDR_WIDTH'($urandom_range(0, 7));
   endfunction

   initial begin
      for (int i = 0; i < NUM_REGS; i++) begin
         model_regs[i] = '0;
         model_busy[i] = 1'b0;
      end

      // Initial reset; DUT state is unknown beforehand so nothing is compared.
      applyStimulus(1'b1, 0, 0, 1'b0, 0, 1'b0, 0, '0);
      advance();

      // Load junk into data and scoreboard.
      step(1'b0, 0, 0, 1'b1, 5,  1'b1, 1,  32'hFFFF_0001);
      step(1'b0, 0, 0, 1'b1, 31, 1'b1, 5,  32'hFFFF_0005);
      step(1'b0, 0, 0, 1'b1, 7,  1'b1, 31, 32'hFFFF_001F);
      // Reset with a coincident writeback and issue, both of which are dropped.
      step(1'b1, 1, 5, 1'b1, 9, 1'b1, 9, 32'h0000_0BAD);

      applyStimulus(1'b0, 1, 5, 1'b1, 31, 1'b0, 0, '0);
      checkOutput();
      checkValue("rst_x1", rs1_data, 32'h0);
      checkValue("rst_x5", rs2_data, 32'h0);
      checkValue("rst_stall", 32'(stall), 32'h0);
      advance();
      applyStimulus(1'b0, 31, 7, 1'b0, 0, 1'b0, 0, '0);
      checkOutput();
      checkValue("rst_x31", rs1_data, 32'h0);
      checkValue("rst_busy_x7", 32'(rs2_busy), 32'h0);
      advance();

      // Ordinary write/read and the x0 sink.
      step(1'b0, 0, 0, 1'b0, 0, 1'b1, 7, 32'hDEAD_BEEF);
      applyStimulus(1'b0, 7, 0, 1'b0, 0, 1'b0, 0, '0);
      checkOutput();
      checkValue("read_x7", rs1_data, 32'hDEAD_BEEF);
      advance();
      step(1'b0, 0, 0, 1'b0, 0, 1'b1, 0, 32'h0000_1234);
      applyStimulus(1'b0, 0, 0, 1'b0, 0, 1'b0, 0, '0);
      checkOutput();
      checkValue("read_x0", rs1_data, 32'h0);
      advance();

      // RAW hazard on x3.
      step(1'b0, 0, 0, 1'b1, 3, 1'b0, 0, '0);
      applyStimulus(1'b0, 3, 0, 1'b1, 0, 1'b0, 0, '0);
      checkOutput();
      checkValue("raw_stall", 32'(stall), 32'h1);
      advance();
      step(1'b0, 3, 0, 1'b1, 0, 1'b0, 0, '0);
      applyStimulus(1'b0, 3, 0, 1'b1, 0, 1'b1, 3, 32'h55);
      checkOutput();
`ifdef REGFILE_BYPASS_EN
      checkValue("raw_wb_stall", 32'(stall), 32'h0);
      checkValue("raw_wb_data", rs1_data, 32'h55);
`else
      checkValue("raw_wb_stall", 32'(stall), 32'h1);
`endif
      advance();
      applyStimulus(1'b0, 3, 0, 1'b1, 0, 1'b0, 0, '0);
      checkOutput();
      checkValue("raw_after_stall", 32'(stall), 32'h0);
      checkValue("raw_after_data", rs1_data, 32'h55);
      advance();

      // WAW with simultaneous writeback and re-issue of x4.
      step(1'b0, 0, 0, 1'b1, 4, 1'b0, 0, '0);
      applyStimulus(1'b0, 0, 0, 1'b1, 4, 1'b1, 4, 32'h44);
      checkOutput();
`ifdef REGFILE_BYPASS_EN
      checkValue("waw_stall", 32'(stall), 32'h0);
`else
      checkValue("waw_stall", 32'(stall), 32'h1);
`endif
      advance();
      applyStimulus(1'b0, 4, 0, 1'b0, 0, 1'b0, 0, '0);
      checkOutput();
`ifdef REGFILE_BYPASS_EN
      checkValue("waw_busy_x4", 32'(rs1_busy), 32'h1);
`else
      checkValue("waw_busy_x4", 32'(rs1_busy), 32'h0);
`endif
      advance();
      step(1'b0, 0, 0, 1'b0, 0, 1'b1, 4, 32'h45);

      // Reset while x9 has a pending write, then a late writeback.
      step(1'b0, 0, 0, 1'b1, 9, 1'b0, 0, '0);
      applyStimulus(1'b0, 0, 9, 1'b0, 0, 1'b0, 0, '0);
      checkOutput();
      checkValue("mid_busy_x9", 32'(rs2_busy), 32'h1);
      advance();
      step(1'b1, 0, 9, 1'b0, 0, 1'b0, 0, '0);
      applyStimulus(1'b0, 0, 9, 1'b0, 0, 1'b0, 0, '0);
      checkOutput();
      checkValue("mid_rst_busy", 32'(rs2_busy), 32'h0);
      checkValue("mid_rst_data", rs2_data, 32'h0);
      advance();
      step(1'b0, 0, 0, 1'b0, 0, 1'b1, 9, 32'hA5);
      applyStimulus(1'b0, 0, 9, 1'b0, 0, 1'b0, 0, '0);
      checkOutput();
      checkValue("late_wb_x9", rs2_data, 32'hA5);
      advance();

      // Both ports on x12 while it is written.
      step(1'b0, 0, 0, 1'b0, 0, 1'b1, 12, 32'h1111);
      applyStimulus(1'b0, 12, 12, 1'b0, 0, 1'b1, 12, 32'hCAFE);
      checkOutput();
`ifdef REGFILE_BYPASS_EN
      checkValue("dual_rs1_now", rs1_data, 32'hCAFE);
      checkValue("dual_rs2_now", rs2_data, 32'hCAFE);
`else
      checkValue("dual_rs1_now", rs1_data, 32'h1111);
      checkValue("dual_rs2_now", rs2_data, 32'h1111);
`endif
      advance();
      applyStimulus(1'b0, 12, 12, 1'b0, 0, 1'b0, 0, '0);
      checkOutput();
      checkValue("dual_rs1_next", rs1_data, 32'hCAFE);
      checkValue("dual_rs2_next", rs2_data, 32'hCAFE);
      advance();

      // Randomized traffic concentrated on a few registers to provoke hazards.
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 49) == 0), randAddr(), randAddr(), 1'($urandom),
              randAddr(), 1'($urandom), randAddr(), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
